hack_cpu_core: RTL and testbench
================================

Name: hack_cpu_core

Overview:
Hack CPU control/datapath core. It is the driver end of the hack_alu interface. It decodes Hack A- and C-instructions and holds the A, D and PC registers. It drives hack_alu's x/y operands and zx/nx/zy/ny/f/no control bits, and consumes its out/zr/ng results for destination writes and jumps. hack_alu is instantiated alongside this block at the top level, not inside it.

Parameters:
PC_W, 15, width of pc and address_m (Hack ROM/RAM address space)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst_n  in  1  synchronous, active-low reset
instr_valid  in  1  instruction present this cycle; 0 = stall (hold all state)
instruction  in  16  Hack instruction fetched from ROM[pc]
in_m  in  16  RAM[address_m] read data
out_m  out  16  RAM write data
write_m  out  1  RAM write enable
address_m  out  PC_W  RAM address
pc  out  PC_W  program counter / ROM address
alu_x  out  16  ALU x operand
alu_y  out  16  ALU y operand
alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits
alu_out  in  16  ALU result
alu_zr  in  1  ALU zero flag
alu_ng  in  1  ALU negative flag

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset: when rst_n=0 at a rising edge, A, D and pc become 0. While rst_n=0, write_m=0 combinationally. Reset mid-stall or mid-program aborts the current instruction with no RAM write.
- Decode: instruction[15]=0 is an A-instruction. instruction[15]=1 is a C-instruction; bits [14:13] are ignored.
- C fields: a=[12]; {zx,nx,zy,ny,f,no}=[11:6]; dest {A,D,M}=[5:3]; jump {lt,eq,gt}=[2:0].
- ALU drive is combinational from the current instruction:
  - alu_x = D.
  - alu_y = a ? in_m : A.
  - Control bits = [11:6] for a C-instruction, 6'b000000 for an A-instruction.
- A-instruction, when instr_valid=1: A <= {1'b0, instruction[14:0]}; D unchanged; pc <= pc+1; write_m=0.
- C-instruction, when instr_valid=1:
  - out_m = alu_out.
  - write_m = dest M.
  - address_m = current A[PC_W-1:0], i.e. before any update this cycle.
  - At the edge: if dest A, A <= alu_out; if dest D, D <= alu_out.
  - Jump taken = (lt & alu_ng) | (eq & alu_zr) | (gt & ~alu_ng & ~alu_zr).
  - pc <= taken ? current A[PC_W-1:0] : pc+1. Jump uses the pre-update A even when dest A is set.
- Simultaneous dest AMD: all three use the same alu_out. The RAM address is the old A.
- instr_valid=0: A, D and pc hold; write_m=0. alu_* and out_m are still driven from the current inputs.
- pc arithmetic: pc+1 is modulo 2^PC_W, so 0x7FFF wraps to 0x0000.
- out_m is don't-care when write_m=0.
- Latency: decode, ALU drive and write_m are combinational within the cycle. Register and pc effects are visible one edge later.

Test Plan:
- Reset: rst_n=0 for 2 cycles with instruction=0xE308 valid -> pc=0, A=0, D=0, write_m=0 throughout; after release pc increments 0,1,2.
- 0x00AB then 0xEC10 (D=A) -> the second cycle drives ctrl 110000 with alu_y=0x00AB; after the edge D=0x00AB, pc=2.
- 0x1234 then 0xE090 (D=D+A) with D=0x00AB -> ctrl 000010, alu_x=0x00AB, alu_y=0x1234; D becomes 0x12DF.
- 0x0010 then 0xE308 (M=D) with D=0x12DF -> write_m=1, out_m=0x12DF, address_m=0x0010; A and D unchanged.
- Jumps:
  - A=0x0100, D=0, 0xE302 (D;JEQ) -> pc=0x0100.
  - D=5, 0xE302 -> pc=pc+1.
  - D=5, 0xE301 (D;JGT) -> pc=0x0100.
  - 0xEA87 (0;JMP) -> pc=A.
- Stall and wrap:
  - instr_valid=0 for 3 cycles -> pc, A and D frozen; write_m=0.
  - pc=0x7FFF with an A-instruction -> pc=0x0000.
  - 0xEC27 (A=A;JMP) with A=0x0040 -> pc=0x0040 (old A), A=0x0040.

Source files
------------

// File: rtl/hack_cpu_core.sv
// hack_cpu_core: Hack CPU decode, A/D/PC registers, drives an external hack_alu.
module hack_cpu_core #(
  parameter int PC_W = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [15:0]     instruction,
  input  logic [15:0]     in_m,
  output logic [15:0]     out_m,
  output logic            write_m,
  output logic [PC_W-1:0] address_m,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     alu_x,
  output logic [15:0]     alu_y,
  output logic            alu_zx,
  output logic            alu_nx,
  output logic            alu_zy,
  output logic            alu_ny,
  output logic            alu_f,
  output logic            alu_no,
  input  logic [15:0]     alu_out,
  input  logic            alu_zr,
  input  logic            alu_ng
);
  localparam logic [PC_W-1:0] PC_ONE = 1;
  logic [15:0] a_q, a_d, d_q, d_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic is_c, taken;
  logic [2:0] dst, jmp;
  always_comb begin
    is_c = instruction[15];
    dst = instruction[5:3];
    jmp = instruction[2:0];
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = is_c ? instruction[11:6] : 6'b000000;
    alu_x = d_q;
    alu_y = (is_c && instruction[12]) ? in_m : a_q;
    out_m = alu_out;
    address_m = a_q[PC_W-1:0];
    pc = pc_q;
    write_m = rst_n & instr_valid & is_c & dst[0];
    taken = is_c & ((jmp[2] & alu_ng) | (jmp[1] & alu_zr) | (jmp[0] & ~alu_ng & ~alu_zr));
    a_d = !instr_valid ? a_q : !is_c ? {1'b0, instruction[14:0]} : dst[2] ? alu_out : a_q;
    d_d = (instr_valid && is_c && dst[1]) ? alu_out : d_q;
    pc_d = !instr_valid ? pc_q : taken ? a_q[PC_W-1:0] : pc_q + PC_ONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      d_q <= '0;
      pc_q <= '0;
    end else begin
      a_q <= a_d;
      d_q <= d_d;
      pc_q <= pc_d;
    end
  end
endmodule

// File: tb/tb_hack_cpu_core.sv
// tb_hack_cpu_core: reference-model bench with a behavioural hack_alu attached.
module tb_hack_cpu_core;
  logic clk = 0;
  logic rst_n, instr_valid;
  logic [15:0] instruction, in_m, out_m, alu_x, alu_y, alu_out;
  logic write_m, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
  logic [14:0] address_m, pc;
  int errs = 0;
  int checks = 0;
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  logic m_ok = 0;

  always #5 clk = ~clk;

  hack_cpu_core #(.PC_W(15)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instruction(instruction),
    .in_m(in_m), .out_m(out_m), .write_m(write_m), .address_m(address_m), .pc(pc),
    .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
    .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out),
    .alu_zr(alu_zr), .alu_ng(alu_ng)
  );

  function automatic logic [15:0] alu_fn(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] a, b, o;
    a = c[5] ? 16'h0000 : x;
    if (c[4]) a = ~a;
    b = c[3] ? 16'h0000 : y;
    if (c[2]) b = ~b;
    o = c[1] ? a + b : a & b;
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign alu_out = alu_fn(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
  assign alu_zr = (alu_out == 16'h0000);
  assign alu_ng = alu_out[15];

  task automatic do_step(input logic r, input logic v, input logic [15:0] ins, input logic [15:0] inm);
    logic c, ew, tk;
    logic [5:0] ec;
    logic [15:0] ey, res;
    rst_n = r; instr_valid = v; instruction = ins; in_m = inm;
    #1;
    c = ins[15];
    ec = c ? ins[11:6] : 6'b000000;
    ey = ins[12] ? inm : m_a;
    res = alu_fn(m_d, ey, ec);
    ew = r & v & c & ins[3];
    checks++;
    if (write_m !== ew) begin errs++; $display("FAIL write_m ins=%h got=%b exp=%b", ins, write_m, ew); end
    checks++;
    if ({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} !== ec) begin
      errs++; $display("FAIL ctrl ins=%h got=%b exp=%b", ins, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, ec);
    end
    if (m_ok) begin
      checks++;
      if (alu_x !== m_d) begin errs++; $display("FAIL alu_x ins=%h got=%h exp=%h", ins, alu_x, m_d); end
      if (c) begin
        checks++;
        if (alu_y !== ey) begin errs++; $display("FAIL alu_y ins=%h got=%h exp=%h", ins, alu_y, ey); end
      end
      if (ew) begin
        checks++;
        if (out_m !== res) begin errs++; $display("FAIL out_m ins=%h got=%h exp=%h", ins, out_m, res); end
        checks++;
        if (address_m !== m_a[14:0]) begin errs++; $display("FAIL address_m ins=%h got=%h exp=%h", ins, address_m, m_a[14:0]); end
      end
    end
    if (!r) begin
      m_a = 0; m_d = 0; m_pc = 0; m_ok = 1;
    end else if (v && m_ok) begin
      if (!c) begin
        m_a = {1'b0, ins[14:0]};
        m_pc = m_pc + 15'd1;
      end else begin
        tk = (ins[2] && $signed(res) < 0) || (ins[1] && res == 0) || (ins[0] && $signed(res) > 0);
        m_pc = tk ? m_a[14:0] : m_pc + 15'd1;
        if (ins[5]) m_a = res;
        if (ins[4]) m_d = res;
      end
    end
    @(posedge clk);
    #1;
    if (m_ok) begin
      checks++;
      if (pc !== m_pc) begin errs++; $display("FAIL pc ins=%h got=%h exp=%h", ins, pc, m_pc); end
      checks++;
      if (address_m !== m_a[14:0]) begin errs++; $display("FAIL reg_a ins=%h got=%h exp=%h", ins, address_m, m_a[14:0]); end
      checks++;
      if (alu_x !== m_d) begin errs++; $display("FAIL reg_d ins=%h got=%h exp=%h", ins, alu_x, m_d); end
    end
  endtask

  task automatic test_reset;
    do_step(0, 1, 16'hE308, 16'h1111);
    do_step(0, 1, 16'hE308, 16'h1111);
    for (int i = 0; i < 3; i++) do_step(1, 1, 16'h0000, 16'h0000);
  endtask

  task automatic test_alu_dest;
    do_step(1, 1, 16'h00AB, 16'h0);
    do_step(1, 1, 16'hEC10, 16'h0);
    do_step(1, 1, 16'h1234, 16'h0);
    do_step(1, 1, 16'hE090, 16'h0);
    do_step(1, 1, 16'h0010, 16'h0);
    do_step(1, 1, 16'hE308, 16'h0);
    do_step(1, 1, 16'hFC10, 16'h5A5A);
    do_step(1, 1, 16'hEC38, 16'h0);
  endtask

  task automatic test_jumps;
    do_step(1, 1, 16'h0100, 16'h0);
    do_step(1, 1, 16'hEA90, 16'h0);
    do_step(1, 1, 16'hE302, 16'h0);
    do_step(1, 1, 16'h0005, 16'h0);
    do_step(1, 1, 16'hEC10, 16'h0);
    do_step(1, 1, 16'h0100, 16'h0);
    do_step(1, 1, 16'hE302, 16'h0);
    do_step(1, 1, 16'hE301, 16'h0);
    do_step(1, 1, 16'hEE84, 16'h0);
    do_step(1, 1, 16'hEA87, 16'h0);
  endtask

  task automatic test_stall;
    for (int i = 0; i < 3; i++) do_step(1, 0, (i == 0) ? 16'hE308 : 16'($urandom), 16'($urandom));
    do_step(0, 0, 16'hE308, 16'h0);
    do_step(1, 1, 16'h0003, 16'h0);
  endtask

  task automatic test_wrap;
    do_step(1, 1, 16'h7FFF, 16'h0);
    do_step(1, 1, 16'hEA87, 16'h0);
    do_step(1, 1, 16'h0040, 16'h0);
    do_step(1, 1, 16'hEC27, 16'h0);
    do_step(1, 1, 16'h7FFF, 16'h0);
    do_step(1, 1, 16'hEA87, 16'h0);
    do_step(1, 1, 16'h0001, 16'h0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++)
      do_step($urandom_range(0, 49) != 0, $urandom_range(0, 4) != 0, 16'($urandom), 16'($urandom));
  endtask

  initial begin
    rst_n = 0; instr_valid = 0; instruction = 0; in_m = 0;
    test_reset;
    test_alu_dest;
    test_jumps;
    test_stall;
    test_wrap;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
